// File: rtl/cable_tester_monitor.sv
// cable_tester_monitor: decodes demux write strobes arriving from a cable under
// test, checks that channels sweep 0..31 in order, counts sequence errors and
// complete sweeps, and flags the link as lost when writes stop arriving.
// Build option: define CABLE_INV_INPUT_EN for the board variant whose cable
// drivers invert every pin; the pins are then inverted after synchronization.
module cable_tester_monitor #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena_in,
    input  logic        wr_in,
    input  logic        cs_in,
    input  logic [4:0]  set_ch_in,
    output logic        ch_valid,
    output logic [4:0]  ch_out,
    output logic        seq_err,
    output logic [15:0] err_cnt,
    output logic [15:0] pass_cnt,
    output logic        link_up,
    output logic        timeout
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

`ifdef CABLE_INV_INPUT_EN
    // Inverted variant: idle cable level is all ones.
    localparam logic [7:0] INV_MASK = 8'hFF;
`else
    localparam logic [7:0] INV_MASK = 8'h00;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_TRACK   = 2'd2,
        S_LOST    = 2'd3
    } state_t;

    // Pin order inside the synchronizer: {ena, wr, cs, set_ch[4:0]}
    logic [7:0]    r_meta;
    logic [7:0]    r_sync;
    logic [7:0]    w_pins;
    logic          w_ena;
    logic          w_wr;
    logic          w_cs;
    logic [4:0]    w_set_ch;
    logic          r_stb_q;
    logic          r_stb_d;
    logic          w_wr_evt;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [4:0]    r_exp;
    logic [4:0]    w_exp_nxt;
    logic [5:0]    r_run;
    logic [5:0]    w_run_nxt;
    logic [5:0]    w_run_upd;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    logic [4:0]    r_ch;
    logic [4:0]    w_ch_nxt;
    logic          r_seq;
    logic          w_seq_nxt;
    logic [15:0]   r_err;
    logic [15:0]   w_err_nxt;
    logic [15:0]   r_pass;
    logic [15:0]   w_pass_nxt;
    logic          r_tmo;
    logic          w_tmo_nxt;
    logic          r_link;

    // Two-flop synchronizer for every cable pin, cleared to the idle cable level
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta <= INV_MASK;
            r_sync <= INV_MASK;
        end else begin
            r_meta <= {ena_in, wr_in, cs_in, set_ch_in};
            r_sync <= r_meta;
        end
    end

    assign w_pins   = r_sync ^ INV_MASK;
    assign w_ena    = w_pins[7];
    assign w_wr     = w_pins[6];
    assign w_cs     = w_pins[5];
    assign w_set_ch = w_pins[4:0];

    // Extra strobe stage plus its delayed copy for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stb_q <= 1'b0;
            r_stb_d <= 1'b0;
        end else begin
            r_stb_q <= w_cs & w_wr;
            r_stb_d <= r_stb_q;
        end
    end

    // A write only counts while ena is still high in the event cycle
    assign w_wr_evt = r_stb_q & ~r_stb_d & w_ena;

    // Next-state and next-output logic; ena low overrides any write handling
    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_run_nxt   = r_run;
        w_run_upd   = r_run;
        w_timer_nxt = r_timer;
        w_valid_nxt = 1'b0;
        w_ch_nxt    = r_ch;
        w_seq_nxt   = 1'b0;
        w_err_nxt   = r_err;
        w_pass_nxt  = r_pass;
        w_tmo_nxt   = r_tmo;
        if (!w_ena) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
        end else if (w_wr_evt) begin
            w_valid_nxt = 1'b1;
            w_ch_nxt    = w_set_ch;
            w_tmo_nxt   = 1'b0;
            w_timer_nxt = '0;
            w_state_nxt = S_TRACK;
            w_exp_nxt   = w_set_ch + 5'd1;
            if (r_state != S_TRACK) begin
                // Baseline write: start of a new run
                w_run_upd = 6'd1;
            end else if (w_set_ch == r_exp) begin
                w_run_upd = r_run + 6'd1;
            end else begin
                w_seq_nxt = 1'b1;
                w_err_nxt = (r_err == 16'hFFFF) ? r_err : r_err + 16'd1;
                w_run_upd = 6'd1;
            end
            if (w_set_ch == 5'd31) begin
                // Channel 31 closes a sweep; only a full 32-write run scores
                if ((w_run_upd == 6'd32) && (r_pass != 16'hFFFF)) begin
                    w_pass_nxt = r_pass + 16'd1;
                end else begin
                    w_pass_nxt = r_pass;
                end
                w_run_nxt = 6'd0;
            end else begin
                w_run_nxt = w_run_upd;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ACQUIRE;
                    w_timer_nxt = '0;
                end
                S_TRACK: begin
                    if ((r_timer + TW'(1)) == TMO_LIMIT) begin
                        w_state_nxt = S_LOST;
                        w_tmo_nxt   = 1'b1;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                default: begin
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_exp   <= 5'd0;
            r_run   <= 6'd0;
            r_timer <= '0;
            r_valid <= 1'b0;
            r_ch    <= 5'd0;
            r_seq   <= 1'b0;
            r_err   <= 16'd0;
            r_pass  <= 16'd0;
            r_tmo   <= 1'b0;
            r_link  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
            r_run   <= w_run_nxt;
            r_timer <= w_timer_nxt;
            r_valid <= w_valid_nxt;
            r_ch    <= w_ch_nxt;
            r_seq   <= w_seq_nxt;
            r_err   <= w_err_nxt;
            r_pass  <= w_pass_nxt;
            r_tmo   <= w_tmo_nxt;
            r_link  <= (w_state_nxt == S_TRACK);
        end
    end

    assign ch_valid = r_valid;
    assign ch_out   = r_ch;
    assign seq_err  = r_seq;
    assign err_cnt  = r_err;
    assign pass_cnt = r_pass;
    assign link_up  = r_link;
    assign timeout  = r_tmo;
endmodule
